// File: rtl/wide_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer_if
//   Groups the request, response and shared-adder signals of
//   wide_add_sequencer into one bundle.
//
//   Parameter CHUNKS : number of 16-bit chunks, operand width W = 16*CHUNKS.
//
//   Request  : req_valid, req_ready, req_a[W], req_b[W], req_sub
//   Response : rsp_valid, rsp_ready, rsp_sum[W], rsp_cout
//              (+ rsp_ovf when WIDE_ADD_OVF_EN is defined)
//   Adder    : add_a[16], add_b[16], add_cin  -> external combinational adder
//              add_sum[16], add_cout          <- external combinational adder
//
//   Modports:
//     slave  : the sequencer side (accepts requests, drives the adder)
//     master : the surrounding system (issues requests, hosts the adder)
// -----------------------------------------------------------------------------
interface wide_add_sequencer_if #(
    parameter int CHUNKS = 4
) ();
    localparam int W = 16 * CHUNKS;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;

    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
`ifdef WIDE_ADD_OVF_EN
    logic         rsp_ovf;
`endif

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_sum, rsp_cout,
`ifdef WIDE_ADD_OVF_EN
        output rsp_ovf,
`endif
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_sum, rsp_cout,
`ifdef WIDE_ADD_OVF_EN
        input  rsp_ovf,
`endif
        output rsp_ready
    );

endinterface

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//   Performs a 16*CHUNKS-bit add or subtract by time-sharing one external
//   16-bit combinational adder, one chunk per cycle, least significant first.
//   Subtraction is A + ~B + 1: B is inverted on accept and the initial
//   carry-in is the sub flag.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : wide_add_sequencer_if.slave (request, response, adder signals)
//
//   Optional feature macro: WIDE_ADD_OVF_EN
//     When defined, bus.rsp_ovf reports signed two's-complement overflow of
//     the full-width operation, registered alongside rsp_cout.
//
//   Timing: accept edge to rsp_valid is CHUNKS edges; with rsp_ready held
//   high one operation completes every CHUNKS+2 cycles.
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int CHUNKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int W     = 16 * CHUNKS;
    localparam int IDX_W = $clog2(CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands and result are kept as arrays of 16-bit chunks so the
    // active chunk is a simple index by the chunk counter.
    logic [CHUNKS-1:0][15:0] a_reg;
    logic [CHUNKS-1:0][15:0] b_reg;
    logic [CHUNKS-1:0][15:0] sum_reg;
    logic [IDX_W-1:0]        idx;
    logic                    sub_reg;
    logic                    carry;
    logic                    cout_reg;
    logic                    last_chunk;
    logic                    accept;

    assign last_chunk = (idx == IDX_W'(CHUNKS - 1));
    assign accept     = bus.req_valid && bus.req_ready;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.add_a     = 16'h0000;
        bus.add_b     = 16'h0000;
        bus.add_cin   = 1'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The adder is only driven while a chunk is being processed.
                bus.add_a   = a_reg[idx];
                bus.add_b   = b_reg[idx];
                bus.add_cin = (idx == '0) ? sub_reg : carry;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
`ifdef WIDE_ADD_OVF_EN
    logic ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            idx      <= '0;
            sub_reg  <= 1'b0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= bus.req_a;
                        b_reg   <= bus.req_b ^ {W{bus.req_sub}};
                        sub_reg <= bus.req_sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= bus.add_sum;
                    carry        <= bus.add_cout;
                    idx          <= idx + IDX_W'(1);
                    if (last_chunk) begin
                        cout_reg <= bus.add_cout;
`ifdef WIDE_ADD_OVF_EN
                        // Overflow: operands share a sign bit and the result
                        // sign differs; the result sign is this chunk's MSB.
                        ovf_reg  <= (a_reg[CHUNKS-1][15] == b_reg[CHUNKS-1][15]) &&
                                    (bus.add_sum[15] != a_reg[CHUNKS-1][15]);
`endif
                    end
                end
                default: begin
                    // DONE holds the result stable until it is consumed.
                end
            endcase
        end
    end

    assign bus.rsp_sum  = sum_reg;
    assign bus.rsp_cout = cout_reg;
`ifdef WIDE_ADD_OVF_EN
    assign bus.rsp_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
//   Self-checking bench for wide_add_sequencer with CHUNKS=4. Hosts the
//   external 16-bit combinational adder, applies a table of directed vectors,
//   then runs backpressure and reset-abort sequences.
//   Overflow checks are active when WIDE_ADD_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;
    localparam int CHUNKS = 4;
    localparam int NVEC   = 8;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    wide_add_sequencer_if #(.CHUNKS(CHUNKS)) bus ();

    wide_add_sequencer #(.CHUNKS(CHUNKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External shared adder, purely combinational.
    logic [16:0] adder_full;
    assign adder_full   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0000, bus.add_cin};
    assign bus.add_sum  = adder_full[15:0];
    assign bus.add_cout = adder_full[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int n;
        @(negedge clk);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Called right after the accept edge; counts edges until rsp_valid,
    // logs the carry-in of each chunk, then consumes the response.
    task automatic finish_op(output logic [63:0] sum, output logic cout, output logic ovf,
                             output int lat, output logic [15:0] cins);
        lat  = 0;
        cins = '0;
        sum  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            if (lat < 16) cins[lat] = bus.add_cin;
            lat++;
            @(negedge clk);
        end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 64'd0, 64'd1);
            return;
        end
        sum  = bus.rsp_sum;
        cout = bus.rsp_cout;
`ifdef WIDE_ADD_OVF_EN
        ovf  = bus.rsp_ovf;
`endif
        check("adder_quiet_in_done", {31'd0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("idle_after_rsp", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
    endtask

    logic [63:0] got_sum;
    logic        got_cout;
    logic        got_ovf;
    int          got_lat;
    logic [15:0] got_cins;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{a: 64'h0000_0000_0000_FFFF, b: 64'd1, sub: 1'b0,
                    sum: 64'h0000_0000_0001_0000, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, sub: 1'b0,
                    sum: 64'h0, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 64'd5, b: 64'd7, sub: 1'b1,
                    sum: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 64'd7, b: 64'd5, sub: 1'b1,
                    sum: 64'd2, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, sub: 1'b0,
                    sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, sub: 1'b0,
                    sum: 64'h2222_2222_2222_2211, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, sub: 1'b1,
                    sum: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 64'd0, b: 64'd0, sub: 1'b1,
                    sum: 64'd0, cout: 1'b1, ovf: 1'b0};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b0;

        #12;
        check("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("reset_rsp_sum", bus.rsp_sum, 64'd0);
        check("reset_rsp_cout", {63'd0, bus.rsp_cout}, 64'd0);
        check("reset_adder", {31'd0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            finish_op(got_sum, got_cout, got_ovf, got_lat, got_cins);
            check($sformatf("vec%0d_sum", i), got_sum, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), {63'd0, got_cout}, {63'd0, vecs[i].cout});
            check($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(CHUNKS));
`ifdef WIDE_ADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), {63'd0, got_ovf}, {63'd0, vecs[i].ovf});
`endif
            if (i == 0) begin
                // carry-in per chunk: k0=0, k1=1, k2=0, k3=0
                check("vec0_cin_seq", {48'd0, got_cins}, 64'h0000_0000_0000_0002);
            end
        end

        // ---------------- backpressure in DONE ----------------
        start_op(64'd1, 64'd2, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = c[0];
            bus.req_a     = 64'h1111 * 64'(c + 1);
            bus.req_b     = 64'h2222;
            bus.req_sub   = c[1];
            bus.rsp_ready = 1'b0;
            check($sformatf("bp%0d_state", c),
                  {60'd0, bus.rsp_valid, bus.rsp_cout, bus.req_ready, (bus.add_a != 16'h0)},
                  {60'd0, 4'b1000});
            check($sformatf("bp%0d_sum", c), bus.rsp_sum, 64'd3);
            @(negedge clk);
        end
        bus.req_a     = 64'd10;
        bus.req_b     = 64'd20;
        bus.req_sub   = 1'b0;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_release_ready", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        finish_op(got_sum, got_cout, got_ovf, got_lat, got_cins);
        check("bp_next_sum", got_sum, 64'd30);
        check("bp_next_latency", 64'(got_lat), 64'(CHUNKS));

        // ---------------- asynchronous reset abort at k=2 ----------------
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("abort_outputs",
              {61'd0, bus.rsp_valid, bus.rsp_cout, (bus.add_a != 16'h0 || bus.add_b != 16'h0 || bus.add_cin)},
              64'd0);
        check("abort_sum_cleared", bus.rsp_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(64'd3, 64'd4, 1'b0);
        finish_op(got_sum, got_cout, got_ovf, got_lat, got_cins);
        check("post_abort_sum", got_sum, 64'd7);
        check("post_abort_cout", {63'd0, got_cout}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Sequences one shared 16-bit adder (a, b, carry-in to sum, carry-out) so it can perform a wide add or subtract of 16*CHUNKS bits.
- Processes one 16-bit chunk per cycle, least significant first, and propagates the carry through an internal register.
- Sits between a valid/ready request source and the adder instance; the adder itself stays outside this block and is purely combinational.

Parameters:
- CHUNKS, default 4: number of 16-bit chunks. Operand width W = 16*CHUNKS. Legal values are 2 or more.

Ports:
- clk  in  1  : system clock, rising edge.
- rst_n  in  1  : asynchronous, active-low reset.
- req_valid  in  1  : request valid.
- req_ready  out  1  : block idle and able to accept a request.
- req_a  in  W  : operand A.
- req_b  in  W  : operand B.
- req_sub  in  1  : 1 computes A-B, 0 computes A+B.
- add_a  out  16  : chunk of A driven to the shared adder.
- add_b  out  16  : chunk of B (or ~B) driven to the shared adder.
- add_cin  out  1  : carry-in to the shared adder.
- add_sum  in  16  : adder sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  : adder carry-out.
- rsp_valid  out  1  : result valid.
- rsp_ready  in  1  : consumer accepts the result.
- rsp_sum  out  W  : wide result.
- rsp_cout  out  1  : final carry. For subtraction, 1 means no borrow.

Behaviour:
- Reset is asynchronous, active-low, with clock and reset fixed as above.
  - State goes to IDLE; the chunk index, carry register, operand registers and rsp_sum clear to 0.
  - rsp_valid=0, rsp_cout=0, add_a/add_b/add_cin=0, req_ready=1.
- FSM IDLE:
  - req_ready=1.
  - When req_valid&&req_ready at a rising edge: latch A, latch B XOR {W{req_sub}}, latch sub; set index=0; go to RUN.
- FSM RUN (index k = 0..CHUNKS-1):
  - req_ready=0.
  - add_a = A[16k+15:16k] and add_b = B'[16k+15:16k].
  - add_cin = sub when k=0, otherwise the carry register.
  - Each edge: rsp_sum chunk k <= add_sum, carry <= add_cout, k <= k+1.
  - After the edge that processes k=CHUNKS-1: go to DONE, with rsp_cout = that add_cout.
- FSM DONE:
  - rsp_valid=1; rsp_sum and rsp_cout are held stable.
  - When rsp_ready=1 at an edge: go to IDLE. req_ready rises in the following cycle; a request and a response never complete in the same cycle.
- Adder outputs are 0 in IDLE and DONE. The shared adder is only driven in RUN.
- Latency: accept edge to rsp_valid high is exactly CHUNKS edges. Throughput is one operation per CHUNKS+2 cycles when rsp_ready is held at 1.
- Arithmetic is modulo 2^W; carry-out is reported, never saturated.
- req_a, req_b and req_sub are sampled only on the accept edge. Later changes and req_valid pulses during RUN or DONE are ignored.
- rsp_ready while not in DONE has no effect.
- Reset asserted in RUN or DONE aborts the operation. No response is produced and the partial result is cleared.

Optional Feature:
- Macro WIDE_ADD_OVF_EN.
  - Defined: adds output port rsp_ovf (1 bit), the signed two's-complement overflow of the full-width operation. It is set when A[W-1]==B'[W-1] and rsp_sum[W-1]!=A[W-1]. It is registered with rsp_cout, valid under rsp_valid, and resets to 0.
  - Undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- CHUNKS=4, A=0x0000_0000_0000_FFFF, B=1, sub=0 -> rsp_sum=0x0000_0000_0001_0000, rsp_cout=0. rsp_valid rises exactly 4 edges after accept; add_cin sequence is 0,1,0,0.
- A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> rsp_sum=0, rsp_cout=1, rsp_ovf=0.
- Subtraction:
  - A=5, B=7, sub=1 -> rsp_sum=0xFFFF_FFFF_FFFF_FFFE, rsp_cout=0.
  - Then A=7, B=5, sub=1 -> rsp_sum=2, rsp_cout=1.
- WIDE_ADD_OVF_EN defined, A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> rsp_sum=0x8000_0000_0000_0000, rsp_ovf=1, rsp_cout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE while pulsing req_valid with new operands -> rsp_valid, rsp_sum and rsp_cout stay constant, req_ready=0, and no new operation starts. After rsp_ready=1, the next request is accepted one cycle later.
- Drop rst_n asynchronously at k=2 of an operation -> all outputs are 0 immediately and req_ready=1. After release, a new request A=3, B=4 returns rsp_sum=7 with no residue from the aborted operation.
